// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a DEPTH-entry queue between
// the PC generator and decode.
//   clk, rst                : clock, asynchronous active-low reset
//   redirect_valid/pc       : flush the queue and refetch from redirect_pc
//   imem_req_valid/ready/addr : pipelined fetch request (credit limited)
//   imem_rsp_valid/data     : in-order fetch responses, one per request
//   out_valid/ready/pc/instr: queue head towards decode
//   occupancy               : number of valid queue entries
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic            run_q;
  logic            valid_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic [CW-1:0]   live;
  logic [XLEN-1:0] rsp_pc;

  // Handshake qualification and PC of the oldest live in-flight request.
  // Live requests were issued back to back since the last redirect, so the
  // oldest one sits live*4 bytes behind fetch_pc; no PC FIFO storage needed.
  always_comb begin
    credit_ok      = (SW'(count_q) + SW'(outst_q)) < SW'(DEPTH);
    imem_req_valid = run_q && credit_ok && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && (outst_q != '0);
    push           = rsp_ok && (drop_q == '0) && !redirect_valid;
    pop            = valid_q && out_ready && !redirect_valid;
    live           = outst_q - drop_q;
    rsp_pc         = fetch_pc_q - (XLEN'(live) << 2);
  end

  // Next-state logic; a redirect overrides every other event.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - CW'(rsp_ok);
      // Everything still in flight after this cycle is stale.
      drop_d     = outst_q - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      count_d = count_q + CW'(push) - CW'(pop);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_ok);
      drop_d  = drop_q - CW'(rsp_ok && (drop_q != '0));
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      valid_q    <= 1'b0;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      valid_q    <= (count_d != '0);
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue payload storage; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc;
      instr_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

  assign imem_req_addr = fetch_pc_q;
  assign out_valid     = valid_q;
  assign out_pc        = pc_mem[rd_ptr_q];
  assign out_instr     = instr_mem[rd_ptr_q];
  assign occupancy     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model plus in-order memory model.
module tb_fetch_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_instr;
  logic [CW-1:0]   occupancy;
  logic            w_req_valid, w_out_valid;
  logic [XLEN-1:0] w_req_addr, w_out_pc, w_out_instr;
  logic [CW-1:0]   w_occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy));

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
    .occupancy(w_occupancy));

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct packed { longint due; logic [31:0] addr; } mreq_t;

  ent_t        m_q[$];
  logic [31:0] m_pend[$];
  int          m_outst, m_drop;
  logic [31:0] m_fpc;
  bit          m_run;
  mreq_t       mem_q[$];
  longint      cyc, last_due;
  int          lat_min, lat_max;
  int          total, bad;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic bit m_req_valid();
    return m_run && (m_q.size() + m_outst < int'(DEPTH)) && !redirect_valid;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete(); m_pend.delete(); mem_q.delete();
    m_outst = 0; m_drop = 0; m_fpc = 32'h0; m_run = 0;
    last_due = cyc;
    imem_rsp_valid = 1'b0;
  endtask

  // Advance model and memory by the cycle that just ended, then present the
  // memory response for the new cycle.
  task automatic step();
    bit fire, rok;
    mreq_t r;
    ent_t e;
    if (!rst) model_reset();
    else begin
      fire = m_req_valid() && imem_req_ready;
      rok  = imem_rsp_valid && (m_outst > 0);
      if (fire) begin
        r.due = cyc + longint'($urandom_range(lat_max, lat_min));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        r.addr = m_fpc;
        mem_q.push_back(r);
      end
      if (redirect_valid) begin
        m_q.delete(); m_pend.delete();
        if (rok) m_outst--;
        m_drop = m_outst;
        m_fpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (rok) begin
          m_outst--;
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = m_pend.pop_front();
            e.instr = imem_rsp_data;
            m_q.push_back(e);
          end
        end
        if (fire) begin
          m_pend.push_back(m_fpc);
          m_outst++;
          m_fpc = m_fpc + 32'd4;
        end
      end
      m_run = 1;
    end
    cyc++;
    if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
  endtask

  task automatic reset_block();
    tick();
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("req_valid", 32'(imem_req_valid), 32'(m_req_valid()));
    chk("req_addr", imem_req_addr, m_fpc);
    if (m_q.size() > 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
    total++;
    if (imem_rsp_valid && m_outst == 0) begin
      bad++;
      $display("FAIL rsp_protocol: response with nothing outstanding (cycle %0d)", cyc);
    end
  end

  initial begin
    int hs, fov, np, nw, na, stale, vseen;
    bit done, got, gotp;
    logic [31:0] ppc [4];
    logic [31:0] pin [4];
    logic [31:0] wpc [4];
    logic [31:0] adr [4];
    logic [31:0] first_addr, first_pc, victim, hold;

    total = 0; bad = 0; cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b1; imem_rsp_data = '0;
    model_reset();

    // Reset values.
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_w_req_addr", w_req_addr, 32'hFFFF_FFF8);

    // Latency 1, decode always ready; also the wrapping instance.
    tick(); rst = 1'b1;
    hs = -1; fov = -1; np = 0; nw = 0; na = 0;
    for (int i = 0; i < 4; i++) begin ppc[i] = 32'hDEAD_BEEF; pin[i] = 32'hDEAD_BEEF; wpc[i] = 32'hDEAD_BEEF; adr[i] = 32'hDEAD_BEEF; end
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (hs < 0) hs = int'(cyc);
        if (na < 3) begin adr[na] = imem_req_addr; na++; end
      end
      if (out_valid && fov < 0) fov = int'(cyc);
      if (out_valid && out_ready && np < 3) begin ppc[np] = out_pc; pin[np] = out_instr; np++; end
      if (w_out_valid && out_ready && nw < 3) begin wpc[nw] = w_out_pc; nw++; end
    end
    chk("lat1_first_out_delay", 32'(fov - hs), 32'd2);
    chk("lat1_addr0", adr[0], 32'h0);
    chk("lat1_addr1", adr[1], 32'h4);
    chk("lat1_addr2", adr[2], 32'h8);
    chk("lat1_pc0", ppc[0], 32'h0);
    chk("lat1_pc1", ppc[1], 32'h4);
    chk("lat1_pc2", ppc[2], 32'h8);
    chk("lat1_instr0", pin[0], 32'h5A5A_1234);
    chk("lat1_instr1", pin[1], 32'h5A5A_1230);
    chk("lat1_instr2", pin[2], 32'h5A5A_123C);
    chk("wrap_pc0", wpc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", wpc[2], 32'h0);

    // Decode stalled, latency 3: credit limit fills the queue.
    lat_min = 3; lat_max = 3;
    reset_block();
    out_ready = 1'b0; na = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) na++;
    end
    chk("stall_req_count", 32'(na), 32'd4);
    chk("stall_occupancy", 32'(occupancy), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    np = 0; got = 0; first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) ppc[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready && np < 4) begin ppc[np] = out_pc; np++; end
      if (imem_req_valid && imem_req_ready && !got) begin first_addr = imem_req_addr; got = 1; end
    end
    chk("drain_pc0", ppc[0], 32'h0);
    chk("drain_pc1", ppc[1], 32'h4);
    chk("drain_pc2", ppc[2], 32'h8);
    chk("drain_pc3", ppc[3], 32'hC);
    chk("drain_resume_addr", first_addr, 32'h10);

    // Redirect with two requests in flight, latency 4.
    lat_min = 4; lat_max = 4;
    reset_block();
    done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!done && m_outst == 2) begin redirect_valid = 1'b1; redirect_pc = 32'h103; done = 1; end
      @(negedge clk);
      if (done) break;
    end
    chk("redir_taken", 32'(done), 32'd1);
    got = 0; gotp = 0; stale = 0; first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && !got) begin first_addr = imem_req_addr; got = 1; end
      if (out_valid && out_ready) begin
        if (!gotp) begin first_pc = out_pc; gotp = 1; end
        if (out_pc < 32'h100) stale++;
      end
    end
    chk("redir_next_addr", first_addr, 32'h100);
    chk("redir_first_pc", first_pc, 32'h100);
    chk("redir_stale_out", 32'(stale), 32'd0);

    // Redirect coinciding with a live response and a pop, latency 2.
    lat_min = 2; lat_max = 2;
    reset_block();
    done = 0; victim = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done && imem_rsp_valid && m_outst > 0 && m_drop == 0 && m_q.size() > 0 && out_ready) begin
        victim = m_pend[0];
        redirect_valid = 1'b1; redirect_pc = 32'h200; done = 1;
      end
      @(negedge clk);
      if (done) break;
    end
    chk("same_cycle_taken", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    chk("same_cycle_occupancy", 32'(occupancy), 32'd0);
    chk("same_cycle_out_valid", 32'(out_valid), 32'd0);
    vseen = 0; gotp = 0; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (!gotp) begin first_pc = out_pc; gotp = 1; end
        if (out_pc == victim) vseen++;
      end
    end
    chk("same_cycle_victim_seen", 32'(vseen), 32'd0);
    chk("same_cycle_first_pc", first_pc, 32'h200);

    // Request backpressure for 5 cycles.
    hold = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      imem_req_ready = 1'b0;
      if (i == 0) hold = m_fpc;
      @(negedge clk);
      chk("hold_addr", imem_req_addr, hold);
    end
    na = 0;
    for (int i = 0; i < 4; i++) adr[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      imem_req_ready = 1'b1;
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && na < 2) begin adr[na] = imem_req_addr; na++; end
    end
    chk("hold_release_addr0", adr[0], hold);
    chk("hold_release_addr1", adr[1], hold + 32'd4);

    // Randomised traffic with redirects and occasional mid-run reset.
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      tick();
      out_ready      = ($urandom % 4) != 0;
      imem_req_ready = ($urandom % 4) != 0;
      if (($urandom % 30) == 0) begin redirect_valid = 1'b1; redirect_pc = $urandom; end
      if (($urandom % 400) == 0) begin rst = 1'b0; model_reset(); end
      else rst = 1'b1;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
